// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit with signed/unsigned flags, optional saturation
// and valid/ready handshakes; arithmetic happens in slot 0, later slots only carry it forward.
module addsub_pipe #(
  parameter int WIDTH    = 64,
  parameter int STAGES   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] L_UMAX = '1;
  localparam logic [WIDTH-1:0] L_SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] L_SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_sov;
  logic             w_ovf;

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_cy;
  logic [STAGES-1:0] r_ov;
  logic [WIDTH-1:0]  r_res [STAGES];
  logic [STAGES-1:0] w_en;
  logic [STAGES-1:0] w_adv;

  always_comb begin
    w_sum   = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    w_carry = w_sum[WIDTH];
    // On overflow the true result always carries the sign of a.
    if (op) w_sov = (a[WIDTH-1] != b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    else    w_sov = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    w_ovf = signed_mode ? w_sov : w_carry;
    w_res = w_sum[WIDTH-1:0];
    if (SATURATE) begin
      if (signed_mode && w_sov)        w_res = a[WIDTH-1] ? L_SMIN : L_SMAX;
      else if (!signed_mode && w_carry) w_res = op ? '0 : L_UMAX;
    end
  end

  // A slot may load when it is empty or its content moves on this cycle;
  // this ripples from the output back to in_ready so a full pipe never bubbles.
  always_comb begin : ctl
    logic v_en;
    v_en  = out_ready;
    w_en  = '0;
    w_adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = r_vld[k] & v_en;
      w_en[k]  = ~r_vld[k] | w_adv[k];
      v_en     = w_en[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_cy  <= '0;
      r_ov  <= '0;
      for (int k = 0; k < STAGES; k++) r_res[k] <= '0;
    end else begin
      if (w_en[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) begin
          r_res[0] <= w_res;
          r_cy[0]  <= w_carry;
          r_ov[0]  <= w_ovf;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_en[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_res[k] <= r_res[k-1];
            r_cy[k]  <= r_cy[k-1];
            r_ov[k]  <= r_ov[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = w_en[0];
  assign out_valid = r_vld[STAGES-1];
  assign result    = r_res[STAGES-1];
  assign carry     = r_cy[STAGES-1];
  assign overflow  = r_ov[STAGES-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: four configurations driven side by side, each checked
// against a true-arithmetic reference model through per-instance scoreboards.
module tb_addsub_pipe;

  localparam int WD [4] = '{64, 64, 8, 33};
  localparam int SD [4] = '{2, 2, 1, 5};
  localparam bit SA [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct {
    logic [63:0] r;
    logic        cy;
    logic        ov;
    int          t;
    bit          lat;
  } bt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  logic        in_v  [4];
  logic [63:0] st_a  [4];
  logic [63:0] st_b  [4];
  logic        st_op [4];
  logic        st_sm [4];

  wire [3:0]  i_rdy, o_vld, o_cy, o_ov;
  wire [63:0] res0, res1;
  wire [7:0]  res2;
  wire [32:0] res3;

  bt_t q [4][$];
  bit  acc [4];
  int  nx [4];
  int  bp_next [4];
  int  n_cmp = 0;
  int  n_err = 0;
  int  tick_no = 0;
  bit  chk_lat = 1'b0;
  bit  bp_mode = 1'b0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(64), .STAGES(2), .SATURATE(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_v[0]), .in_ready(i_rdy[0]), .a(st_a[0]), .b(st_b[0]),
    .op(st_op[0]), .signed_mode(st_sm[0]), .out_valid(o_vld[0]), .out_ready(out_ready),
    .result(res0), .carry(o_cy[0]), .overflow(o_ov[0]));
  addsub_pipe #(.WIDTH(64), .STAGES(2), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_v[1]), .in_ready(i_rdy[1]), .a(st_a[1]), .b(st_b[1]),
    .op(st_op[1]), .signed_mode(st_sm[1]), .out_valid(o_vld[1]), .out_ready(out_ready),
    .result(res1), .carry(o_cy[1]), .overflow(o_ov[1]));
  addsub_pipe #(.WIDTH(8), .STAGES(1), .SATURATE(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_v[2]), .in_ready(i_rdy[2]), .a(st_a[2][7:0]), .b(st_b[2][7:0]),
    .op(st_op[2]), .signed_mode(st_sm[2]), .out_valid(o_vld[2]), .out_ready(out_ready),
    .result(res2), .carry(o_cy[2]), .overflow(o_ov[2]));
  addsub_pipe #(.WIDTH(33), .STAGES(5), .SATURATE(1'b1)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_v[3]), .in_ready(i_rdy[3]), .a(st_a[3][32:0]), .b(st_b[3][32:0]),
    .op(st_op[3]), .signed_mode(st_sm[3]), .out_valid(o_vld[3]), .out_ready(out_ready),
    .result(res3), .carry(o_cy[3]), .overflow(o_ov[3]));

  function automatic logic [63:0] get_res(int id);
    case (id)
      0:       return res0;
      1:       return res1;
      2:       return {56'd0, res2};
      default: return {31'd0, res3};
    endcase
  endfunction

  // Reference: evaluate the exact mathematical sum/difference, then derive flags and clamping.
  function automatic bt_t model(int w, bit sat, logic [63:0] a, logic [63:0] b, bit op, bit sm);
    logic signed [67:0] one, modv, mask, ua, ub, sa, sb, tu, ts, smax, smin, tmp;
    bit sov;
    bt_t e;
    one  = 68'sd1;
    modv = one <<< w;
    mask = modv - one;
    ua   = $signed({4'b0, a}) & mask;
    ub   = $signed({4'b0, b}) & mask;
    sa   = ua[w-1] ? ua - modv : ua;
    sb   = ub[w-1] ? ub - modv : ub;
    tu   = op ? ua - ub : ua + ub;
    ts   = op ? sa - sb : sa + sb;
    smax = (one <<< (w - 1)) - one;
    smin = -(one <<< (w - 1));
    e.cy = (tu < 0) || (tu > mask);
    sov  = (ts > smax) || (ts < smin);
    e.ov = sm ? sov : e.cy;
    tmp  = tu & mask;
    if (sat && sm && sov) tmp = (ts > 0) ? smax : (smin & mask);
    else if (sat && !sm && e.cy) tmp = op ? 68'sd0 : mask;
    e.r   = tmp[63:0];
    e.t   = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  function automatic logic [63:0] rnd(int w);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = (64'd1 << (w - 1)) - 64'd1;
      3: v = 64'd1 << (w - 1);
      4: v = 64'd1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called just after a falling edge with inputs settled; checks, scores and advances one cycle.
  task automatic tick();
    bt_t e;
    #1;
    for (int id = 0; id < 4; id++) begin
      chk($sformatf("in_ready[%0d]", id), 64'(i_rdy[id]),
          64'(!((q[id].size() == SD[id]) && !out_ready)));
      if (o_vld[id]) begin
        n_cmp++;
        assert (q[id].size() != 0)
        else begin
          n_err++;
          $error("FAIL stale[%0d] observed=out_valid expected=idle", id);
        end
        if (q[id].size() != 0) begin
          e = q[id][0];
          chk($sformatf("result[%0d]", id), get_res(id), e.r);
          chk($sformatf("carry[%0d]", id), 64'(o_cy[id]), 64'(e.cy));
          chk($sformatf("overflow[%0d]", id), 64'(o_ov[id]), 64'(e.ov));
          if (out_ready && e.lat)
            chk($sformatf("latency[%0d]", id), 64'(tick_no - e.t), 64'(SD[id]));
          if (bp_mode && out_ready) begin
            chk($sformatf("bp_order[%0d]", id), get_res(id), 64'(bp_next[id]));
            bp_next[id]++;
          end
          if (out_ready) void'(q[id].pop_front());
        end
      end
      acc[id] = in_v[id] && i_rdy[id];
      if (acc[id]) begin
        e     = model(WD[id], SA[id], st_a[id], st_b[id], st_op[id], st_sm[id]);
        e.t   = tick_no;
        e.lat = chk_lat;
        q[id].push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    tick_no++;
  endtask

  task automatic set_all(bit v, logic [63:0] a, logic [63:0] b, bit op, bit sm);
    for (int id = 0; id < 4; id++) begin
      in_v[id]  = v;
      st_a[id]  = a;
      st_b[id]  = b;
      st_op[id] = op;
      st_sm[id] = sm;
    end
  endtask

  task automatic drain();
    int left;
    out_ready = 1'b1;
    set_all(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      left = q[0].size() + q[1].size() + q[2].size() + q[3].size();
      if (left == 0) break;
      tick();
    end
    chk("drain_left", 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 64'd0);
  endtask

  // One beat to every instance, then the 64-bit pair is checked two cycles after acceptance.
  task automatic directed(string tag, logic [63:0] a, logic [63:0] b, bit op, bit sm,
                          logic [63:0] r0, bit c0, bit v0, logic [63:0] r1, bit c1, bit v1);
    set_all(1'b1, a, b, op, sm);
    tick();
    set_all(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    tick();
    #1;
    chk({tag, "_vld0"}, 64'(o_vld[0]), 64'd1);
    chk({tag, "_res0"}, res0, r0);
    chk({tag, "_cy0"},  64'(o_cy[0]), 64'(c0));
    chk({tag, "_ov0"},  64'(o_ov[0]), 64'(v0));
    chk({tag, "_vld1"}, 64'(o_vld[1]), 64'd1);
    chk({tag, "_res1"}, res1, r1);
    chk({tag, "_cy1"},  64'(o_cy[1]), 64'(c1));
    chk({tag, "_ov1"},  64'(o_ov[1]), 64'(v1));
  endtask

  initial begin
    bit busy;
    rst       = 1'b0;
    out_ready = 1'b1;
    set_all(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    for (int id = 0; id < 4; id++) begin
      chk($sformatf("rst_vld[%0d]", id), 64'(o_vld[id]), 64'd0);
      chk($sformatf("rst_res[%0d]", id), get_res(id), 64'd0);
      chk($sformatf("rst_cy[%0d]", id), 64'(o_cy[id]), 64'd0);
      chk($sformatf("rst_ov[%0d]", id), 64'(o_ov[id]), 64'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    directed("usub_5_7", 64'd5, 64'd7, 1'b1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 64'd0, 1'b1, 1'b1);
    directed("usub_100_58", 64'd100, 64'd58, 1'b1, 1'b0,
             64'd42, 1'b0, 1'b0, 64'd42, 1'b0, 1'b0);
    directed("sadd_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    directed("usub_3_9", 64'd3, 64'd9, 1'b1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b1, 64'd0, 1'b1, 1'b1);
    directed("uadd_max_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    drain();

    // Reset with two beats in flight: outputs clear at once and nothing stale appears later.
    set_all(1'b1, 64'd20, 64'd3, 1'b0, 1'b0);
    tick();
    set_all(1'b1, 64'd21, 64'd4, 1'b1, 1'b1);
    tick();
    set_all(1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    for (int id = 0; id < 4; id++) begin
      chk($sformatf("midrst_vld[%0d]", id), 64'(o_vld[id]), 64'd0);
      chk($sformatf("midrst_res[%0d]", id), get_res(id), 64'd0);
      q[id].delete();
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int id = 0; id < 4; id++)
      chk($sformatf("postrst_rdy[%0d]", id), 64'(i_rdy[id]), 64'd1);
    repeat (8) tick();

    // Backpressure stream a=i, b=1, subtract: results 0..9 in order per instance.
    bp_mode = 1'b1;
    for (int id = 0; id < 4; id++) begin
      nx[id]      = 1;
      bp_next[id] = 0;
    end
    for (int c = 0; c < 300; c++) begin
      busy = 1'b0;
      for (int id = 0; id < 4; id++)
        if (nx[id] <= 10 || q[id].size() != 0) busy = 1'b1;
      if (!busy) break;
      out_ready = 1'($urandom_range(0, 1));
      for (int id = 0; id < 4; id++) begin
        in_v[id]  = (nx[id] <= 10);
        st_a[id]  = 64'(nx[id]);
        st_b[id]  = 64'd1;
        st_op[id] = 1'b1;
        st_sm[id] = 1'b0;
      end
      tick();
      for (int id = 0; id < 4; id++)
        if (acc[id]) nx[id]++;
    end
    drain();
    for (int id = 0; id < 4; id++)
      chk($sformatf("bp_count[%0d]", id), 64'(bp_next[id]), 64'd10);
    bp_mode = 1'b0;

    // Random operations with out_ready held high: exact results and latency == STAGES.
    chk_lat   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int id = 0; id < 4; id++) begin
        in_v[id]  = ($urandom_range(0, 3) != 0);
        st_a[id]  = rnd(WD[id]);
        st_b[id]  = rnd(WD[id]);
        st_op[id] = 1'($urandom_range(0, 1));
        st_sm[id] = 1'($urandom_range(0, 1));
      end
      tick();
    end
    drain();
    chk_lat = 1'b0;

    // Random operations under random backpressure.
    for (int c = 0; c < 400; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      for (int id = 0; id < 4; id++) begin
        in_v[id]  = 1'($urandom_range(0, 1));
        st_a[id]  = rnd(WD[id]);
        st_b[id]  = rnd(WD[id]);
        st_op[id] = 1'($urandom_range(0, 1));
        st_sm[id] = 1'($urandom_range(0, 1));
      end
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the combinational 64-bit subtractor.
- Adds configurable width and pipeline depth, an add/sub opcode, signed/unsigned flags, optional saturation and a valid/ready handshake on both sides.
- Sits between the DPI-driven stimulus front-end and result checker in the arithmetic datapath; one operation accepted per cycle.

Parameters:
- WIDTH, 64, operand/result width in bits (legal range 2..64).
- STAGES, 2, pipeline register stages; legal range 1..8; equals latency with no backpressure.
- SATURATE, 0, 1 = clamp result on overflow/borrow; 0 = wrap modulo 2^WIDTH.

Ports:
- clk, input, 1, single clock; rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, operand beat present.
- in_ready, output, 1, unit can accept a beat this cycle.
- a, input, WIDTH, minuend or first addend.
- b, input, WIDTH, subtrahend or second addend.
- op, input, 1, 0 = a+b, 1 = a-b.
- signed_mode, input, 1, 1 = two's-complement overflow/saturation rules; 0 = unsigned.
- out_valid, output, 1, result beat present.
- out_ready, input, 1, downstream accepts the result.
- result, output, WIDTH, sum or difference.
- carry, output, 1, add: carry-out; sub: borrow (a < b unsigned). Raw, pre-saturation.
- overflow, output, 1, signed overflow if signed_mode=1, else equals carry. Raw.

Behaviour:
- Reset (asynchronous, any time): all stage valids clear. out_valid=0, result=0, carry=0, overflow=0, in_ready=1 after release. In-flight beats are discarded; there is no partial completion.
- Handshake: beat accepted when in_valid & in_ready. Output consumed when out_valid & out_ready. Once asserted, out_valid and result/flags hold stable until consumed.
- Pipeline: STAGES register slots, each with its own valid bit.
  - Slot k loads from slot k-1 when slot k is empty or slot k is advancing that cycle.
  - Last slot advances on out_ready.
  - in_ready = ~slot0_valid | slot0_advancing, which is combinational through the chain. No bubbles.
  - Full throughput: 1 beat/cycle with out_ready held high.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, so it is visible in the cycle following edge N+STAGES-1. For STAGES=1 it is visible the cycle after acceptance.
- Arithmetic: computed in WIDTH+1 bits in stage 0. Later stages only carry the result forward.
  - Sub: {borrow,diff} = {0,a} - {0,b}.
  - Signed overflow when operand sign bits meet the add/sub rule and the result sign differs.
- Saturation (SATURATE=1):
  - Unsigned add with carry gives all-ones; unsigned sub with borrow gives 0.
  - Signed overflow gives the positive max if the true result is positive, else the negative min.
  - carry and overflow still report the raw condition.
- Backpressure: out_ready=0 with the pipe full makes in_ready=0 and retains all data. Releasing out_ready resumes with no loss or duplication, and order is preserved.
- Simultaneous accept and consume on a full pipe is legal and keeps throughput.
- op and signed_mode are sampled with the beat; changing them per beat is legal.

Test Plan:
- Reset/idle: assert rst mid-stream with 2 beats in flight -> out_valid=0 and result=0 immediately. After release, in_ready=1 and no stale beat ever emerges.
- Unsigned sub, WIDTH=64, STAGES=2, SATURATE=0: a=5, b=7, op=1 -> result=0xFFFF_FFFF_FFFF_FFFE, carry=1, appearing 2 cycles after accept. a=100, b=58 -> result=42, carry=0.
- Signed overflow, signed_mode=1: a=0x7FFF_FFFF_FFFF_FFFF, b=1, op=0 -> wrap gives 0x8000_0000_0000_0000 with overflow=1. With SATURATE=1 -> 0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Unsigned saturation, SATURATE=1: a=3, b=9, op=1, signed_mode=0 -> result=0, carry=1. a=all-ones, b=1, op=0 -> all-ones, carry=1.
- Backpressure: stream beats 1..10 (a=i, b=1, sub) with out_ready toggling on a random 50% pattern -> results 0..9 in order, none lost or duplicated. in_ready=0 only when the pipe is full and not draining.
- Parameter sweep: WIDTH=8, STAGES=1 and WIDTH=33, STAGES=5 with random ops, checked against a reference model -> exact match of result, carry and overflow. Latency equals STAGES when out_ready=1.
